// File: rtl/divider_28bit_sequential.sv
// divider_28bit_sequential
// ------------------------------------------------------------------
// Iterative radix-2 restoring divider. It divides an unsigned
// 2*WIDTH-bit dividend by a WIDTH-bit divisor and resolves one
// quotient bit per clock.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The source holds its payload stable while valid=1 && ready=0. ready
// never depends combinationally on valid on the same side.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   operands present          in_ready   operands accepted
//   dividend   2*WIDTH-bit dividend       divisor    WIDTH-bit divisor
//   out_valid  result held on outputs     out_ready  consumer takes result
//   quotient   WIDTH-bit quotient         remainder  WIDTH-bit remainder
//   err        divide-by-zero / quotient overflow flag
//   state_dbg  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Optional feature macro: DIVIDER_OVERFLOW_CHECK_EN
//   When it is defined, a divisor of zero or dividend[2W-1:W] >= divisor is
//   detected on the accepting edge. The divider then goes straight to DONE
//   with err=1, quotient all ones, and remainder=dividend[W-1:0].
//   When it is undefined, err is tied to 0 and every operand pair takes
//   the full WIDTH iterations.
module divider_28bit_sequential #(
  parameter int WIDTH = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               err,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_r;       // partial remainder, one guard bit
  logic [WIDTH-1:0] shift_r;     // low dividend bits still to be consumed
  logic [WIDTH-1:0] quo_r;       // quotient bits gathered so far
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic             last_iter;
  logic             accept;
  logic             bad_ops;

  // The design holds state in IDLE during reset, but in_ready must read 0
  // while rst is low. For that reason the reset level gates the output.
  assign in_ready  = (state == IDLE) && rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (count == CW'(WIDTH - 1));
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign state_dbg = state;

`ifdef DIVIDER_OVERFLOW_CHECK_EN
  logic err_r;
  assign bad_ops = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign err     = err_r;
`else
  assign bad_ops = 1'b0;
  assign err     = 1'b0;
`endif

  // One restoring step. The subtraction uses one extra bit so that its
  // MSB acts as the borrow flag (1 means the trial value < divisor).
  always_comb begin
    trial   = {rem_r[WIDTH-1:0], shift_r[WIDTH-1]};
    diff    = {1'b0, trial} - {2'b00, divisor_r};
    q_bit   = ~diff[WIDTH+1];
    rem_nxt = q_bit ? diff[WIDTH:0] : trial;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_ops ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      rem_r       <= '0;
      shift_r     <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
`ifdef DIVIDER_OVERFLOW_CHECK_EN
      err_r       <= 1'b0;
`endif
    end else if (accept) begin
      rem_r     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
      shift_r   <= dividend[WIDTH-1:0];
      divisor_r <= divisor;
      quo_r     <= '0;
      count     <= '0;
`ifdef DIVIDER_OVERFLOW_CHECK_EN
      if (bad_ops) begin
        quotient_r  <= '1;
        remainder_r <= dividend[WIDTH-1:0];
        err_r       <= 1'b1;
      end else begin
        err_r       <= 1'b0;
      end
`endif
    end else if (state == BUSY) begin
      rem_r   <= rem_nxt;
      shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      quo_r   <= {quo_r[WIDTH-2:0], q_bit};
      count   <= count + 1'b1;
      // The result registers change only on the final iteration, so they
      // keep the previous result stable until the new one is complete.
      if (last_iter) begin
        quotient_r  <= {quo_r[WIDTH-2:0], q_bit};
        remainder_r <= rem_nxt[WIDTH-1:0];
      end
    end
  end

endmodule
